// File: rtl/conv_pkg.sv
// Shared convolution datapath definitions: operand width, accumulator type and
// the ReLU / signed-max helpers used by both the PE and the pooling stage.
package conv_pkg;

   localparam int unsigned WIDTH = 9;
   localparam int unsigned ACC_W = 2 * WIDTH;

   typedef logic signed [ACC_W-1:0] acc_t;

   function automatic acc_t relu(input acc_t x);
      return x[ACC_W-1] ? '0 : x;
   endfunction

   function automatic acc_t smax(input acc_t a, input acc_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Half-row line buffer: one registered write port, combinational read, no reset
// so it can map onto distributed RAM.
module pool_row_buf #(
   parameter int unsigned DEPTH  = 15,
   parameter int unsigned DATA_W = 18,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv_relu_pool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-ordered result stream;
// emits one registered pooled value per completed window.
module conv_relu_pool #(
   parameter int unsigned WIDTH = conv_pkg::WIDTH,
   parameter int unsigned COLS  = 30
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic [2*WIDTH-1:0]   data_in,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   data_out,
   output logic                 out_eol
);
   import conv_pkg::*;

   localparam int unsigned DW   = 2 * WIDTH;
   localparam int unsigned HALF = COLS / 2;
   localparam int unsigned CW   = $clog2(COLS);
   localparam int unsigned AW   = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0]        r_col;
   logic                 r_row_odd;
   logic signed [DW-1:0] r_h_reg;
   logic signed [DW-1:0] r_data_out;
   logic                 r_out_valid;
   logic                 r_out_eol;

   logic [CW-1:0]        w_col;
   logic                 w_row_odd;
   logic                 w_last;
   logic                 w_odd_col;
   logic                 w_wr_en;
   logic                 w_emit;
   logic [AW-1:0]        w_addr;
   logic signed [DW-1:0] w_cur;
   logic signed [DW-1:0] w_h;
   logic [DW-1:0]        w_buf_rd;

   // Start-of-frame overrides the position for the beat that carries it
   always_comb begin
      w_col     = in_sof ? '0 : r_col;
      w_row_odd = in_sof ? 1'b0 : r_row_odd;
      w_last    = (w_col == CW'(COLS - 1));
      w_odd_col = w_col[0];
      w_addr    = AW'(w_col >> 1);
      w_cur     = relu(data_in);
      w_h       = smax(r_h_reg, w_cur);
      w_wr_en   = in_valid & w_odd_col & ~w_row_odd;
      w_emit    = in_valid & w_odd_col & w_row_odd;
   end

   pool_row_buf #(
      .DEPTH  (HALF),
      .DATA_W (DW),
      .ADDR_W (AW)
   ) u_row_buf (
      .clk     (clk),
      .i_we    (w_wr_en),
      .i_addr  (w_addr),
      .i_wdata (w_h),
      .o_rdata (w_buf_rd)
   );

   // With odd COLS the last column is even, so it only loads h_reg and is never paired
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col       <= '0;
         r_row_odd   <= 1'b0;
         r_h_reg     <= '0;
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         r_out_eol   <= 1'b0;
      end else begin
         r_out_valid <= w_emit;
         r_out_eol   <= w_emit && (w_addr == AW'(HALF - 1));
         if (w_emit) r_data_out <= smax(w_h, w_buf_rd);
         if (in_valid) begin
            r_col     <= w_last ? '0 : w_col + CW'(1);
            r_row_odd <= w_last ? ~w_row_odd : w_row_odd;
            if (!w_odd_col) r_h_reg <= w_cur;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign data_out  = r_data_out;
   assign out_eol   = r_out_eol;

endmodule

// File: tb/tb_conv_relu_pool.sv
// Bench for conv_relu_pool: three instances (COLS=4, 5, 30) share one input
// stream; each scenario checks the instance whose geometry it targets.
module tb_conv_relu_pool;

   localparam int unsigned W  = 9;
   localparam int unsigned DW = 2 * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_sof;
   logic [DW-1:0] data_in;

   logic ov4, ov5, ov30, eol4, eol5, eol30;
   logic [DW-1:0] do4, do5, do30;

   always #5 clk = ~clk;

   conv_relu_pool #(.WIDTH(W), .COLS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .data_in(data_in),
      .out_valid(ov4), .data_out(do4), .out_eol(eol4));
   conv_relu_pool #(.WIDTH(W), .COLS(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .data_in(data_in),
      .out_valid(ov5), .data_out(do5), .out_eol(eol5));
   conv_relu_pool #(.WIDTH(W), .COLS(30)) u_dut30 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .data_in(data_in),
      .out_valid(ov30), .data_out(do30), .out_eol(eol30));

   int checks   = 0;
   int failures = 0;

   int frame [4][30];
   int exp_v [$];
   bit exp_e [$];
   int q4_v [$];
   bit q4_e [$];
   int q5_v [$];
   bit q5_e [$];
   int q30_v [$];
   bit q30_e [$];

   always @(negedge clk) begin
      if (ov4)  begin q4_v.push_back(int'(do4));   q4_e.push_back(eol4);   end
      if (ov5)  begin q5_v.push_back(int'(do5));   q5_e.push_back(eol5);   end
      if (ov30) begin q30_v.push_back(int'(do30)); q30_e.push_back(eol30); end
   end

   task automatic beat(input logic v, input logic sof, input int d);
      @(negedge clk);
      in_valid = v;
      in_sof   = sof;
      data_in  = DW'(d);
   endtask

   task automatic idle(input int n);
      repeat (n) beat(1'b0, 1'b0, 0);
   endtask

   task automatic clear_q;
      @(posedge clk);
      q4_v.delete();  q4_e.delete();
      q5_v.delete();  q5_e.delete();
      q30_v.delete(); q30_e.delete();
   endtask

   task automatic fill_random(input int rows, input int cols, input int lo, input int hi);
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++)
            frame[r][c] = lo + int'($urandom_range(0, hi - lo));
   endtask

   task automatic feed(input int rows, input int cols, input int gap_pct);
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) beat(1'b0, 1'b0, 0);
            beat(1'b1, (r == 0 && c == 0), frame[r][c]);
         end
      idle(3);
   endtask

   // Reference: each pooled value is the largest of the four window entries, floored at 0
   function automatic void build_expected(input int rows, input int cols);
      exp_v.delete();
      exp_e.delete();
      for (int pr = 0; pr < rows / 2; pr++)
         for (int pc = 0; pc < cols / 2; pc++) begin
            int m = 0;
            for (int dr = 0; dr < 2; dr++)
               for (int dc = 0; dc < 2; dc++)
                  if (frame[2*pr+dr][2*pc+dc] > m) m = frame[2*pr+dr][2*pc+dc];
            exp_v.push_back(m);
            exp_e.push_back(pc == cols / 2 - 1);
         end
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; data_in = '0;
      repeat (2) @(negedge clk);
      checks++; if (ov4 !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%0b exp=0", ov4); end
      checks++; if (eol4 !== 1'b0) begin failures++; $display("FAIL reset_eol got=%0b exp=0", eol4); end
      checks++; if (do4 !== '0)    begin failures++; $display("FAIL reset_data got=%0d exp=0", do4); end
      checks++; if (ov30 !== 1'b0 || do30 !== '0)
         begin failures++; $display("FAIL reset_dut30 got=%0b/%0d exp=0/0", ov30, do30); end
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_cols4_basic;
      int s [8] = '{1, 5, -3, 2, 4, 0, 7, -9};
      for (int i = 0; i < 8; i++) begin
         logic ev;
         beat(1'b1, (i == 0), s[i]);
         @(posedge clk); #1;
         ev = (i == 5 || i == 7);
         checks++;
         if (ov4 !== ev) begin failures++; $display("FAIL c4_valid[%0d] got=%0b exp=%0b", i, ov4, ev); end
         if (ev) begin
            int ed = (i == 5) ? 5 : 7;
            checks++;
            if (int'(do4) !== ed) begin failures++; $display("FAIL c4_data[%0d] got=%0d exp=%0d", i, do4, ed); end
            checks++;
            if (eol4 !== (i == 7)) begin failures++; $display("FAIL c4_eol[%0d] got=%0b exp=%0b", i, eol4, (i == 7)); end
         end
      end
      idle(2);
   endtask

   task automatic test_all_negative;
      for (int c = 0; c < 4; c++) begin
         frame[0][c] = -1 - c;
         frame[1][c] = -3 - c;
      end
      clear_q();
      feed(2, 4, 0);
      build_expected(2, 4);
      checks++;
      if (q4_v.size() !== exp_v.size()) begin failures++; $display("FAIL neg_count got=%0d exp=%0d", q4_v.size(), exp_v.size()); end
      for (int i = 0; i < exp_v.size() && i < q4_v.size(); i++) begin
         checks++;
         if (q4_v[i] !== exp_v[i] || q4_e[i] !== exp_e[i]) begin
            failures++; $display("FAIL neg_out[%0d] got=%0d/%0b exp=%0d/%0b", i, q4_v[i], q4_e[i], exp_v[i], exp_e[i]);
         end
      end
   endtask

   task automatic test_odd_cols;
      fill_random(4, 5, -50, 50);
      for (int r = 0; r < 4; r++) frame[r][4] = 100;
      clear_q();
      feed(4, 5, 0);
      build_expected(4, 5);
      checks++;
      if (q5_v.size() !== 4) begin failures++; $display("FAIL odd_count got=%0d exp=4", q5_v.size()); end
      for (int i = 0; i < exp_v.size() && i < q5_v.size(); i++) begin
         checks++;
         if (q5_v[i] !== exp_v[i] || q5_e[i] !== exp_e[i]) begin
            failures++; $display("FAIL odd_out[%0d] got=%0d/%0b exp=%0d/%0b", i, q5_v[i], q5_e[i], exp_v[i], exp_e[i]);
         end
      end
   endtask

   task automatic test_random_gaps;
      fill_random(4, 30, -131072, 131071);
      clear_q();
      feed(4, 30, 30);
      build_expected(4, 30);
      checks++;
      if (q30_v.size() !== 30) begin failures++; $display("FAIL gaps_count got=%0d exp=30", q30_v.size()); end
      for (int i = 0; i < exp_v.size() && i < q30_v.size(); i++) begin
         checks++;
         if (q30_v[i] !== exp_v[i] || q30_e[i] !== exp_e[i]) begin
            failures++; $display("FAIL gaps_out[%0d] got=%0d/%0b exp=%0d/%0b", i, q30_v[i], q30_e[i], exp_v[i], exp_e[i]);
         end
      end
   endtask

   task automatic test_sof_mid;
      fill_random(2, 30, -1000, 1000);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 30; c++)
            if (r == 0 || c < 10) beat(1'b1, (r == 0 && c == 0), frame[r][c]);
      idle(1);
      clear_q();
      fill_random(2, 30, -1000, 1000);
      feed(2, 30, 0);
      build_expected(2, 30);
      checks++;
      if (q30_v.size() !== 15) begin failures++; $display("FAIL sof_count got=%0d exp=15", q30_v.size()); end
      for (int i = 0; i < exp_v.size() && i < q30_v.size(); i++) begin
         checks++;
         if (q30_v[i] !== exp_v[i] || q30_e[i] !== exp_e[i]) begin
            failures++; $display("FAIL sof_out[%0d] got=%0d/%0b exp=%0d/%0b", i, q30_v[i], q30_e[i], exp_v[i], exp_e[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      fill_random(2, 30, 1, 5000);
      build_expected(2, 30);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 30; c++)
            if (r == 0 || c < 2) beat(1'b1, (r == 0 && c == 0), frame[r][c]);
      @(posedge clk); #1;
      checks++;
      if (ov30 !== 1'b1 || int'(do30) !== exp_v[0]) begin
         failures++; $display("FAIL rstmid_pending got=%0b/%0d exp=1/%0d", ov30, do30, exp_v[0]);
      end
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
      #1;
      checks++; if (ov30 !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", ov30); end
      checks++; if (do30 !== '0)   begin failures++; $display("FAIL rstmid_data got=%0d exp=0", do30); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_q();
      fill_random(2, 30, -131072, 131071);
      feed(2, 30, 10);
      build_expected(2, 30);
      checks++;
      if (q30_v.size() !== 15) begin failures++; $display("FAIL rstmid_count got=%0d exp=15", q30_v.size()); end
      for (int i = 0; i < exp_v.size() && i < q30_v.size(); i++) begin
         checks++;
         if (q30_v[i] !== exp_v[i] || q30_e[i] !== exp_e[i]) begin
            failures++; $display("FAIL rstmid_out[%0d] got=%0d/%0b exp=%0d/%0b", i, q30_v[i], q30_e[i], exp_v[i], exp_e[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cols4_basic();
      test_all_negative();
      test_odd_cols();
      test_random_gaps();
      test_sof_mid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
